// File: rtl/int_sequencer.sv
// Interrupt and reset sequencer in front of the control FSM's opcode input.
// At an opcode fetch it replaces the memory byte with BRK (8'h00) when an NMI
// or unmasked IRQ is due. The existing BRK sequence then services hardware
// interrupts. It also picks the vector and the pushed B flag value.
module int_sequencer (
  input  logic       ph1,
  input  logic       reset,
  input  logic       nmi_b,
  input  logic       irq_b,
  input  logic       i_flag,
  input  logic       fetch,
  input  logic       vec_fetch,
  input  logic [7:0] mem_data,
  output logic [7:0] ctrl_data,
  output logic [1:0] vec_sel,
  output logic       inhibit_pc_inc,
  output logic       brk_b_flag,
  output logic       int_active
);

  localparam logic [7:0] BrkOpcode = 8'h00;
  localparam logic [1:0] VecNmi    = 2'b01;
  localparam logic [1:0] VecReset  = 2'b10;
  localparam logic [1:0] VecIrqBrk = 2'b11;

  typedef enum logic [1:0] {
    StReset = 2'd0,
    StRun   = 2'd1,
    StInt   = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   nmi_s1_q, nmi_s2_q, nmi_s2_prev_q;
  logic   irq_s1_q, irq_s2_q;
  logic   nmi_pending_q, nmi_pending_d;
  logic   src_q, src_d;          // 1 = NMI, 0 = IRQ
  logic   int_first_q, int_first_d;
  logic   nmi_edge;
  logic   irq_req;
  logic   inject;

  // Two-flop synchronisers for the asynchronous pins, plus a history flop
  // for falling-edge detection on NMI.
  always_ff @(posedge ph1) begin
    if (reset) begin
      nmi_s1_q      <= 1'b1;
      nmi_s2_q      <= 1'b1;
      nmi_s2_prev_q <= 1'b1;
      irq_s1_q      <= 1'b1;
      irq_s2_q      <= 1'b1;
    end else begin
      nmi_s1_q      <= nmi_b;
      nmi_s2_q      <= nmi_s1_q;
      nmi_s2_prev_q <= nmi_s2_q;
      irq_s1_q      <= irq_b;
      irq_s2_q      <= irq_s1_q;
    end
  end

  assign nmi_edge = ~nmi_s2_q & nmi_s2_prev_q;
  // IRQ is a live level request, never latched.
  assign irq_req  = ~irq_s2_q & ~i_flag;

  // Sequencer state registers.
  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q       <= StReset;
      nmi_pending_q <= 1'b0;
      src_q         <= 1'b0;
      int_first_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      nmi_pending_q <= nmi_pending_d;
      src_q         <= src_d;
      int_first_q   <= int_first_d;
    end
  end

  // Next-state logic and combinational outputs.
  always_comb begin
    state_d        = state_q;
    nmi_pending_d  = nmi_pending_q;
    src_d          = src_q;
    int_first_d    = 1'b0;
    inject         = 1'b0;
    ctrl_data      = mem_data;
    vec_sel        = VecReset;
    inhibit_pc_inc = 1'b0;
    brk_b_flag     = 1'b0;
    int_active     = 1'b0;

    unique case (state_q)
      StReset: begin
        // Edges seen while in reset are kept for the first fetch.
        if (nmi_edge) nmi_pending_d = 1'b1;
        if (vec_fetch) state_d = StRun;
      end

      StRun: begin
        vec_sel = VecIrqBrk;
        inject  = fetch & (nmi_pending_q | irq_req);
        if (inject) begin
          ctrl_data      = BrkOpcode;
          inhibit_pc_inc = 1'b1;
          state_d        = StInt;
          src_d          = nmi_pending_q;  // NMI wins over IRQ
          int_first_d    = 1'b1;
          if (nmi_pending_q) nmi_pending_d = 1'b0;
        end else begin
          // Real BRK opcode from memory: B is pushed set.
          brk_b_flag = 1'b1;
        end
        // A fresh edge is never lost, even in the cycle pending is consumed.
        if (nmi_edge) nmi_pending_d = 1'b1;
      end

      StInt: begin
        vec_sel        = src_q ? VecNmi : VecIrqBrk;
        int_active     = 1'b1;
        inhibit_pc_inc = int_first_q;
        if (nmi_edge) begin
          // Hijack an IRQ sequence before its vector is read; otherwise defer.
          if (!src_q && !vec_fetch) src_d = 1'b1;
          else nmi_pending_d = 1'b1;
        end
        if (vec_fetch) state_d = StRun;
      end

      default: begin
        state_d = StReset;
      end
    endcase
  end

endmodule
